dwt_sched: RTL and testbench

Control and scheduling block for the recursive DAUB-4 lifting DWT datapath. It accepts one input sample per cycle for a frame of FRAME_LEN samples and time-multiplexes the single lifting pipeline across up to three decomposition levels. It drives every operand-register enable, operand mux select and delay-unit enable. It tags each result leaving the pipeline so that low-band results are either fed back to the next level's operand registers or flagged as final outputs.

---
 rtl/dwt_pkg.sv | 28 ++
 rtl/dwt_tag_pipe.sv | 34 +++
 rtl/dwt_sched.sv | 196 +++++++++++++++++++
 tb/tb_dwt_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// Shared types for the DAUB-4 lifting DWT scheduler: select codes, FSM states
// and the result tag that travels alongside the lifting pipeline.
package dwt_pkg;

  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_L1   = 2'b01;
  localparam logic [1:0] SEL_L2   = 2'b10;
  localparam logic [1:0] SEL_L3   = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_ERR} state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] level;
    logic       parity;
  } tag_t;

  // Level number (1..3) to operand mux select code.
  function automatic logic [1:0] lvl_sel(input int unsigned lvl);
    case (lvl)
      1:       return SEL_L1;
      2:       return SEL_L2;
      3:       return SEL_L3;
      default: return SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/dwt_tag_pipe.sv
// Depth-DEPTH shift register of result tags that mirrors the lifting pipeline.
// pend flags a valid tag in any stage other than the output stage.
module dwt_tag_pipe
  import dwt_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic pend
);

  tag_t [DEPTH-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = '0;
    if (!clr) begin
      stage_d[0] = tag_in;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
    pend = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pend = pend | stage_q[i].valid;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) stage_q <= '0;
    else         stage_q <= stage_d;

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/dwt_sched.sv
// Scheduler for a single time-multiplexed lifting pipeline serving up to three
// DWT levels: issue slots, operand/delay enables and result tagging.
module dwt_sched
  import dwt_pkg::*;
#(
  parameter int LEVELS    = 3,
  parameter int FRAME_LEN = 64,
  parameter int LAT_FB    = 3,
  parameter int D_DLY     = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEVELS-1:0] en_r,
  output logic [LEVELS-1:0] en_rp,
  output logic [1:0]        sel_even,
  output logic [1:0]        sel_odd,
  output logic [1:0]        sel_d,
  output logic [LEVELS-1:0] en_d,
  output logic              l_valid,
  output logic              h_valid,
  output logic [1:0]        l_level,
  output logic [1:0]        h_level,
  output logic              l_final
);

  localparam int TW = $clog2(FRAME_LEN) + 4;
  localparam int CW = $clog2(FRAME_LEN) + 1;

  state_e                      state_q, state_d;
  logic [TW-1:0]               t_q, t_d;
  logic [LEVELS-1:0]           pair_rdy_q, pair_rdy_d;
  logic [LEVELS-1:0]           issue_q, issue_d;
  logic [LEVELS-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [1:0]                  osel_q, osel_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic [D_DLY-1:0][LEVELS-1:0] den_q;
  logic [D_DLY-1:0][1:0]       dsel_q;

  tag_t              tag_in, tag_out;
  logic              pend, bad, restart, all_done, active_d;
  logic [LEVELS-1:0] cap_r, cap_rp;

  // Feedback captures happen in the cycle the tag leaves the pipeline.
  always_comb begin
    cap_r  = '0;
    cap_rp = '0;
    for (int j = 1; j < LEVELS; j++)
      if (tag_out.valid && tag_out.level == 2'(j)) begin
        if (tag_out.parity) cap_rp[j] = 1'b1;
        else                cap_r[j]  = 1'b1;
      end
  end

  always_comb begin
    tag_in = '0;
    for (int j = 0; j < LEVELS; j++)
      if (issue_q[j]) begin
        tag_in.valid  = 1'b1;
        tag_in.level  = 2'(j + 1);
        tag_in.parity = cnt_q[j][0];
      end
  end

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    err_d      = err_q;
    done_d     = 1'b0;
    restart    = 1'b0;
    bad        = 1'b0;
    pair_rdy_d = (pair_rdy_q & ~issue_q) | cap_rp;
    cnt_d      = cnt_q;
    all_done   = 1'b1;
    for (int j = 0; j < LEVELS; j++) begin
      if (issue_q[j]) cnt_d[j] = cnt_q[j] + CW'(1);
      if (cnt_q[j] != CW'(FRAME_LEN >> (j + 1))) all_done = 1'b0;
    end
    // A second odd operand arriving before the pending pair issued would be lost.
    for (int j = 1; j < LEVELS; j++)
      if (cap_rp[j] && pair_rdy_q[j] && !issue_q[j]) bad = 1'b1;

    case (state_q)
      ST_IDLE: if (start) restart = 1'b1;
      ST_RUN: begin
        t_d = t_q + TW'(1);
        if (!in_valid) bad = 1'b1;
        if (t_q == TW'(FRAME_LEN - 1)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        t_d = t_q + TW'(1);
        // The exiting tag is consumed this cycle, so only earlier stages matter.
        if (all_done && issue_q == '0 && !pend) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (start) restart = 1'b1;
        end
      end
      ST_ERR: if (start) restart = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    if (bad && (state_q == ST_RUN || state_q == ST_FLUSH)) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
      done_d  = 1'b0;
      restart = 1'b0;
    end
    if (restart) begin
      state_d    = ST_RUN;
      t_d        = '0;
      err_d      = 1'b0;
      pair_rdy_d = '0;
      cnt_d      = '0;
    end
    if (state_d == ST_ERR) pair_rdy_d = '0;

    // Issue and selects are registered, so they are decided from next-cycle t.
    active_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    issue_d  = '0;
    osel_d   = SEL_IDLE;
    if (state_d == ST_RUN && t_d[0]) issue_d[0] = 1'b1;
    for (int j = 1; j < LEVELS; j++)
      if (active_d && pair_rdy_d[j] &&
          (t_d & TW'((2 << j) - 1)) == TW'(1 << j))
        issue_d[j] = 1'b1;
    for (int j = 0; j < LEVELS; j++)
      if (issue_d[j]) osel_d = lvl_sel(j + 1);
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      pair_rdy_q <= '0;
      issue_q    <= '0;
      cnt_q      <= '0;
      osel_q     <= SEL_IDLE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      den_q      <= '0;
      dsel_q     <= '0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      pair_rdy_q <= pair_rdy_d;
      issue_q    <= issue_d;
      cnt_q      <= cnt_d;
      osel_q     <= osel_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (state_d == ST_ERR) begin
        den_q  <= '0;
        dsel_q <= '0;
      end else begin
        den_q[0]  <= issue_q;
        dsel_q[0] <= osel_q;
        for (int i = 1; i < D_DLY; i++) begin
          den_q[i]  <= den_q[i-1];
          dsel_q[i] <= dsel_q[i-1];
        end
      end
    end

  dwt_tag_pipe #(.DEPTH(LAT_FB)) u_tags (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (state_d == ST_ERR),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .pend    (pend)
  );

  assign in_ready = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done     = done_q;
  assign err      = err_q;
  assign en_r     = cap_r | LEVELS'(state_q == ST_RUN && !t_q[0]);
  assign en_rp    = cap_rp;
  assign sel_even = osel_q;
  assign sel_odd  = osel_q;
  assign sel_d    = dsel_q[D_DLY-1];
  assign en_d     = den_q[D_DLY-1];
  assign l_valid  = tag_out.valid;
  assign h_valid  = tag_out.valid;
  assign l_level  = tag_out.level;
  assign h_level  = tag_out.level;
  assign l_final  = tag_out.valid && tag_out.level == 2'(LEVELS);

endmodule

// File: tb/tb_dwt_sched.sv
// Directed bench: expected per-cycle output words are queued per frame and
// popped against a LEVELS=3 and a LEVELS=1 instance.
module tb_dwt_sched;

  typedef struct packed {
    logic       rdy, busy, done, err;
    logic [2:0] en_r, en_rp, en_d;
    logic [1:0] sel, sel_e, sel_d;
    logic       lv, hv;
    logic [1:0] lvl, hlvl;
    logic       fin;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, start3, start1, in_valid;

  logic       in_ready3, busy3, done3, err3, l_valid3, h_valid3, l_final3;
  logic [2:0] en_r3, en_rp3, en_d3;
  logic [1:0] sel_even3, sel_odd3, sel_d3, l_level3, h_level3;

  logic       in_ready1, busy1, done1, err1, l_valid1, h_valid1, l_final1;
  logic [0:0] en_r1, en_rp1, en_d1;
  logic [1:0] sel_even1, sel_odd1, sel_d1, l_level1, h_level1;

  dwt_sched #(.LEVELS(3), .FRAME_LEN(8), .LAT_FB(3), .D_DLY(2)) dut3 (
    .clk(clk), .resetn(resetn), .start(start3), .in_valid(in_valid),
    .in_ready(in_ready3), .busy(busy3), .done(done3), .err(err3),
    .en_r(en_r3), .en_rp(en_rp3), .sel_even(sel_even3), .sel_odd(sel_odd3),
    .sel_d(sel_d3), .en_d(en_d3), .l_valid(l_valid3), .h_valid(h_valid3),
    .l_level(l_level3), .h_level(h_level3), .l_final(l_final3)
  );

  dwt_sched #(.LEVELS(1), .FRAME_LEN(8), .LAT_FB(3), .D_DLY(2)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .in_valid(in_valid),
    .in_ready(in_ready1), .busy(busy1), .done(done1), .err(err1),
    .en_r(en_r1), .en_rp(en_rp1), .sel_even(sel_even1), .sel_odd(sel_odd1),
    .sel_d(sel_d1), .en_d(en_d1), .l_valid(l_valid1), .h_valid(h_valid1),
    .l_level(l_level1), .h_level(h_level1), .l_final(l_final1)
  );

  int   total = 0;
  int   bad   = 0;
  obs_t sb[$];
  obs_t ref_tr [0:31];

  function automatic obs_t obs3();
    obs_t o;
    o = '{rdy: in_ready3, busy: busy3, done: done3, err: err3,
          en_r: en_r3, en_rp: en_rp3, en_d: en_d3,
          sel: sel_odd3, sel_e: sel_even3, sel_d: sel_d3,
          lv: l_valid3, hv: h_valid3, lvl: l_level3, hlvl: h_level3,
          fin: l_final3};
    return o;
  endfunction

  function automatic obs_t obs1();
    obs_t o;
    o = '{rdy: in_ready1, busy: busy1, done: done1, err: err1,
          en_r: {2'b00, en_r1}, en_rp: {2'b00, en_rp1}, en_d: {2'b00, en_d1},
          sel: sel_odd1, sel_e: sel_even1, sel_d: sel_d1,
          lv: l_valid1, hv: h_valid1, lvl: l_level1, hlvl: h_level1,
          fin: l_final1};
    return o;
  endfunction

  // Expected trace of one clean frame (FRAME_LEN=8, LAT_FB=3, D_DLY=2).
  task automatic build(input int lv, input int ncyc);
    int it[7] = '{1, 3, 5, 7, 10, 14, 20};
    int il[7] = '{1, 1, 1, 1, 2, 2, 3};
    int ik[7] = '{0, 1, 0, 1, 0, 1, 0};
    int n;
    n = (lv == 3) ? 7 : 4;
    for (int t = 0; t < 32; t++) ref_tr[t] = '0;
    for (int t = 0; t < 8; t++) begin
      ref_tr[t].rdy     = 1'b1;
      ref_tr[t].en_r[0] = (t % 2 == 0);
    end
    for (int t = 0; t < ncyc; t++) ref_tr[t].busy = 1'b1;
    ref_tr[ncyc].done = 1'b1;
    for (int i = 0; i < n; i++) begin
      ref_tr[it[i]].sel   = 2'(il[i]);
      ref_tr[it[i]].sel_e = 2'(il[i]);
      ref_tr[it[i]+2].en_d[il[i]-1] = 1'b1;
      ref_tr[it[i]+2].sel_d = 2'(il[i]);
      ref_tr[it[i]+3].lv    = 1'b1;
      ref_tr[it[i]+3].hv    = 1'b1;
      ref_tr[it[i]+3].lvl   = 2'(il[i]);
      ref_tr[it[i]+3].hlvl  = 2'(il[i]);
      if (il[i] == lv)      ref_tr[it[i]+3].fin = 1'b1;
      else if (ik[i] == 0)  ref_tr[it[i]+3].en_r[il[i]]  = 1'b1;
      else                  ref_tr[it[i]+3].en_rp[il[i]] = 1'b1;
    end
  endtask

  task automatic push_range(input int a, input int b);
    for (int t = a; t <= b; t++) sb.push_back(ref_tr[t]);
  endtask

  task automatic check(input string tag, input obs_t o, input obs_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  // One pop/compare per cycle, sampled 1 time unit after the rising edge.
  task automatic run_check(input string tag, input int which,
                           input int vdrop, input int sdrop);
    int   idx = 0;
    obs_t e;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      check($sformatf("%s t=%0d", tag, idx), (which == 3) ? obs3() : obs1(), e);
      if (idx == sdrop) begin start3 = 1'b0; start1 = 1'b0; end
      if (idx == vdrop) in_valid = 1'b0;
      if (idx == vdrop + 1) in_valid = 1'b1;
      idx++;
    end
  endtask

  initial begin
    obs_t e;
    resetn = 1'b1; start3 = 1'b0; start1 = 1'b0; in_valid = 1'b1;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset3", obs3(), '0);
    check("reset1", obs1(), '0);
    @(negedge clk) resetn = 1'b1;

    build(3, 24);
    push_range(0, 25);
    @(negedge clk) start3 = 1'b1;
    run_check("basic", 3, -10, 0);

    // in_valid dropped at t=5: ERR from t=6 with only err left high
    push_range(0, 5);
    e = '0; e.err = 1'b1;
    repeat (4) sb.push_back(e);
    @(negedge clk) start3 = 1'b1;
    run_check("verr", 3, 5, 0);
    push_range(0, 25);
    @(negedge clk) start3 = 1'b1;
    run_check("restart", 3, -10, 0);

    build(1, 11);
    push_range(0, 12);
    @(negedge clk) start1 = 1'b1;
    run_check("lev1", 1, -10, 0);

    // asynchronous reset at t=9
    build(3, 24);
    push_range(0, 9);
    @(negedge clk) start3 = 1'b1;
    run_check("prerst", 3, -10, 0);
    #1 resetn = 1'b0;
    #1 check("async_rst", obs3(), '0);
    @(negedge clk) resetn = 1'b1;
    push_range(0, 25);
    @(negedge clk) start3 = 1'b1;
    run_check("postrst", 3, -10, 0);

    // back-to-back: second frame's t=0 coincides with the done pulse
    push_range(0, 23);
    e = ref_tr[0]; e.done = 1'b1;
    sb.push_back(e);
    push_range(1, 25);
    @(negedge clk) start3 = 1'b1;
    run_check("b2b", 3, -10, 27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
